// File: rtl/matmul_issue_scheduler.sv
// Issue scheduler for one NxN matrix multiply on a shared pipelined MAC.
// Walks (i,j,k) one tuple per cycle and tracks completions through a tag pipe.
module matmul_issue_scheduler #(
    parameter int N        = 3,
    parameter int PIPE_LAT = 3,
    parameter int IDX_W    = 2,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              issue_vld,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              acc_clr,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    localparam int TAG_AW = PIPE_LAT * ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                i_q, i_d, j_q, j_d, k_q, k_d;
    logic                            busy_q, busy_d;
    logic                            issue_vld_q, issue_vld_d;
    logic                            done_q, done_d;
    logic [15:0]                     stall_cnt_q, stall_cnt_d;
    logic [PIPE_LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [PIPE_LAT-1:0]             tag_last_q, tag_last_d;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] tag_addr_q, tag_addr_d;

    logic              accept;
    logic              k_wrap, j_wrap, i_wrap;
    logic [ADDR_W-1:0] ik_addr, kj_addr, ij_addr;

    always_comb begin
        accept  = (state_q == S_ISSUE) && !stall;
        k_wrap  = (k_q == IDX_W'(N - 1));
        j_wrap  = (j_q == IDX_W'(N - 1));
        i_wrap  = (i_q == IDX_W'(N - 1));
        ik_addr = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
        kj_addr = ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
        ij_addr = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
    end

    // Tag pipe mirrors the MAC: frozen by stall, otherwise shifts in the accepted issue or a bubble.
    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_last_d = tag_last_q;
        tag_addr_d = tag_addr_q;
        if (!stall) begin
            tag_vld_d  = (tag_vld_q << 1) | PIPE_LAT'(accept);
            tag_last_d = (tag_last_q << 1) | PIPE_LAT'(accept & k_wrap);
            tag_addr_d = (tag_addr_q << ADDR_W) | TAG_AW'(accept ? ij_addr : '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        busy_d      = busy_q;
        issue_vld_d = issue_vld_q;
        done_d      = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (busy_q && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ISSUE;
                    busy_d      = 1'b1;
                    issue_vld_d = 1'b1;
                    i_d         = '0;
                    j_d         = '0;
                    k_d         = '0;
                    stall_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    k_d = k_wrap ? '0 : k_q + IDX_W'(1);
                    if (k_wrap) begin
                        j_d = j_wrap ? '0 : j_q + IDX_W'(1);
                        if (j_wrap) begin
                            i_d = i_wrap ? '0 : i_q + IDX_W'(1);
                            if (i_wrap) begin
                                state_d     = S_DRAIN;
                                issue_vld_d = 1'b0;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!stall && (tag_vld_d == '0)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            issue_vld_q <= 1'b0;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
            tag_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            issue_vld_q <= issue_vld_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_last_q  <= tag_last_d;
            tag_addr_q  <= tag_addr_d;
        end
    end

    always_comb begin
        busy      = busy_q;
        issue_vld = issue_vld_q;
        a_addr    = issue_vld_q ? ik_addr : '0;
        b_addr    = issue_vld_q ? kj_addr : '0;
        acc_clr   = issue_vld_q && (k_q == '0);
        done      = done_q;
        stall_cnt = stall_cnt_q;
        c_we      = tag_vld_q[PIPE_LAT-1] & tag_last_q[PIPE_LAT-1] & !stall;
        c_addr    = c_we ? tag_addr_q[PIPE_LAT-1] : '0;
    end

endmodule

// File: tb/tb_matmul_issue_scheduler.sv
// Directed self-checking bench for matmul_issue_scheduler (N=3, PIPE_LAT=3).
module tb_matmul_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        busy, issue_vld, acc_clr, c_we, done;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0_cyc = 0;
    logic mon_en = 1'b0;

    int         cwe_rel_q[$];
    int         cwe_addr_q[$];
    int         done_rel_q[$];
    logic [8:0] tup_q[$];
    int         n_vld = 0;
    int         bad_caddr = 0;

    matmul_issue_scheduler #(.N(3), .PIPE_LAT(3), .IDX_W(2), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .issue_vld(issue_vld), .a_addr(a_addr), .b_addr(b_addr),
        .acc_clr(acc_clr), .c_we(c_we), .c_addr(c_addr), .done(done),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (c_we) begin
                cwe_rel_q.push_back(cyc - t0_cyc + 1);
                cwe_addr_q.push_back(int'(c_addr));
            end else if (c_addr != 4'd0) begin
                bad_caddr++;
            end
            if (done) done_rel_q.push_back(cyc - t0_cyc + 1);
            if (issue_vld) n_vld++;
            if (issue_vld && !stall) tup_q.push_back({a_addr, b_addr, acc_clr});
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, busy, issue_vld, a_addr, b_addr, acc_clr, c_we, c_addr, done, stall_cnt};
    endfunction

    task automatic clear_mon();
        cwe_rel_q.delete();
        cwe_addr_q.delete();
        done_rel_q.delete();
        tup_q.delete();
        n_vld = 0;
        bad_caddr = 0;
    endtask

    task automatic do_run(input int stall_rel, input int stall_len, input int restart_rel,
                          input logic [8:0] exp_held, output int done_r, output int sc_at_done);
        start = 1'b1;
        step();
        start = 1'b0;
        t0_cyc = cyc;
        clear_mon();
        mon_en = 1'b1;
        done_r = -1;
        sc_at_done = -1;
        check_eq("busy_first", busy, 1'b1);
        check_eq("stall_cnt_cleared", stall_cnt, 16'd0);
        for (int r = 1; r <= 100; r++) begin
            if (done) begin
                done_r = r;
                sc_at_done = int'(stall_cnt);
                break;
            end
            stall = (stall_len > 0) && (r >= stall_rel) && (r < stall_rel + stall_len);
            start = (r == restart_rel);
            if (stall) check_eq("held_tuple", {issue_vld, a_addr, b_addr, acc_clr}, {1'b1, exp_held});
            step();
            start = 1'b0;
        end
        stall = 1'b0;
        if (done_r < 0) check_eq("done_timeout", 0, 1);
        step();
    endtask

    task automatic check_run(input int stall_rel, input int stall_len, input int done_r, input int sc);
        int e;
        check_eq("cwe_count", cwe_rel_q.size(), 9);
        for (int k = 0; k < cwe_rel_q.size() && k < 9; k++) begin
            e = 3 * k + 6;
            if (stall_len > 0 && e >= stall_rel) e += stall_len;
            check_eq("cwe_time", cwe_rel_q[k], e);
            check_eq("cwe_addr", cwe_addr_q[k], k);
        end
        check_eq("done_count", done_rel_q.size(), 1);
        check_eq("done_time", done_r, 31 + stall_len);
        check_eq("vld_cycles", n_vld, 27 + stall_len);
        check_eq("stall_cnt", sc, stall_len);
        check_eq("caddr_when_idle", bad_caddr, 0);
        check_eq("issue_count", tup_q.size(), 27);
        for (int n = 0; n < tup_q.size() && n < 27; n++) begin
            logic [3:0] ea, eb;
            ea = 4'((n / 9) * 3 + (n % 3));
            eb = 4'((n % 3) * 3 + (n / 3) % 3);
            check_eq("tuple", tup_q[n], {ea, eb, (n % 3) == 0});
        end
        if (tup_q.size() > 9) begin
            check_eq("tuple5", tup_q[5], {4'd2, 4'd7, 1'b0});
            check_eq("tuple9", tup_q[9], {4'd3, 4'd0, 1'b1});
        end
    endtask

    initial begin
        int dr, sc;
        rst = 1'b1;
        repeat (3) step();
        check_eq("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        step();
        check_eq("idle_outs", all_outs(), 64'd0);

        // Plain run
        do_run(0, 0, 0, 9'd0, dr, sc);
        check_run(0, 0, dr, sc);

        // Extra start while busy must be ignored
        do_run(0, 0, 10, 9'd0, dr, sc);
        check_run(0, 0, dr, sc);

        // Four stalled cycles from issue #10 (tuple 1,0,1 held)
        do_run(11, 4, 0, {4'd4, 4'd3, 1'b0}, dr, sc);
        check_run(11, 4, dr, sc);

        // Back-to-back start in the cycle after done
        do_run(0, 0, 0, 9'd0, dr, sc);
        check_run(0, 0, dr, sc);

        // Reset mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrun_reset_outs", all_outs(), 64'd0);
        clear_mon();
        repeat (40) step();
        check_eq("post_reset_cwe", cwe_rel_q.size(), 0);
        check_eq("post_reset_done", done_rel_q.size(), 0);
        check_eq("post_reset_vld", n_vld, 0);
        do_run(0, 0, 0, 9'd0, dr, sc);
        check_run(0, 0, dr, sc);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
